// File: rtl/ipg_tx_arb.sv
// ipg_tx_arb: merges IPG message channels into an encoded 66-bit (2-bit
// sync header + 64-bit block) transmit stream, inserting IPG chunks only
// between net frames and using the net IDLE blocks as rate-matching slack.
//
// Optional build macro: IPG_TX_RR_EN
//   defined   -> round-robin grant among pending channels (rr_ptr present)
//   undefined -> fixed priority, lowest-index pending channel wins
//
// Write interface: ch_wr / net_wr are fire-and-forget strobes with no ready.
// ch_full / net_full are the back-pressure indication; a write presented
// while the target FIFO is full is dropped, even if that FIFO pops in the
// same cycle, and the matching sticky ovf bit is set until reset.
//
// Debug: dbg_state exposes the arbiter FSM state (0=IDLE, 1=NET, 2=IPG).
module ipg_tx_arb #(
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      ch_wr,
  input  logic [64*NUM_CH-1:0]   ch_data,
  input  logic [NUM_CH-1:0]      ch_last,
  input  logic                   net_wr,
  input  logic [1:0]             net_hdr,
  input  logic [63:0]            net_data,
  output logic [1:0]             tx_hdr,
  output logic [63:0]            tx_data,
  output logic [3:0]             tx_src,
  output logic [NUM_CH-1:0]      ch_full,
  output logic                   net_full,
  output logic [NUM_CH:0]        ovf,
  output logic [1:0]             dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NET  = 2'd1;
  localparam logic [1:0] S_IPG  = 2'd2;

  localparam logic [1:0]  IDLE_HDR  = 2'b01;
  localparam logic [63:0] IDLE_DATA = 64'h1e;

  // ---------------------------------------------------------------------
  // Channel FIFOs: entries are {last, data}
  // ---------------------------------------------------------------------
  logic [64:0]       ch_mem  [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0]     ch_wp   [NUM_CH];
  logic [PW-1:0]     ch_rp   [NUM_CH];
  logic [CW-1:0]     ch_cnt  [NUM_CH];
  logic [CW-1:0]     msg_cnt [NUM_CH];
  logic [64:0]       ch_head [NUM_CH];
  logic [NUM_CH-1:0] ch_acc;
  logic [NUM_CH-1:0] ch_pop;
  logic [NUM_CH-1:0] head_last;
  logic [NUM_CH-1:0] pending;

  // ---------------------------------------------------------------------
  // Net FIFO: entries are {hdr, data}
  // ---------------------------------------------------------------------
  logic [65:0]   net_mem [FIFO_DEPTH];
  logic [PW-1:0] net_wp;
  logic [PW-1:0] net_rp;
  logic [CW-1:0] net_cnt;
  logic [65:0]   net_head;
  logic [7:0]    net_type;
  logic          net_acc;
  logic          net_pop;
  logic          net_nempty;
  logic          net_ctrl;
  logic          net_sof;
  logic          net_term;
  logic          net_idleblk;

  // ---------------------------------------------------------------------
  // FSM / arbiter
  // ---------------------------------------------------------------------
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [GW-1:0] grant;
  logic [GW-1:0] arb_grant;
  logic          grant_load;
  logic [1:0]    out_hdr;
  logic [63:0]   out_data;
  logic [3:0]    out_src;

  assign dbg_state = state;

  // Per-channel status: full flag, accepted write, pending message, head
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_full[k]   = (ch_cnt[k] == DEPTH_C);
      ch_acc[k]    = ch_wr[k] & ~ch_full[k];
      pending[k]   = (msg_cnt[k] != '0);
      ch_head[k]   = ch_mem[k][ch_rp[k]];
      head_last[k] = ch_head[k][64];
    end
  end

  // Channel FIFO storage; no reset needed, validity is tracked by ch_cnt
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_acc[k]) ch_mem[k][ch_wp[k]] <= {ch_last[k], ch_data[64*k +: 64]};
    end
  end

  // Channel pointers, occupancy and complete-message counters
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        ch_wp[k]   <= '0;
        ch_rp[k]   <= '0;
        ch_cnt[k]  <= '0;
        msg_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_acc[k]) ch_wp[k] <= ch_wp[k] + 1'b1;
        if (ch_pop[k]) ch_rp[k] <= ch_rp[k] + 1'b1;
        ch_cnt[k]  <= ch_cnt[k] + CW'(ch_acc[k]) - CW'(ch_pop[k]);
        msg_cnt[k] <= msg_cnt[k] + CW'(ch_acc[k] & ch_last[k])
                                 - CW'(ch_pop[k] & head_last[k]);
      end
    end
  end

  // Net FIFO status and head-block classification (type byte is data[7:0])
  always_comb begin
    net_full    = (net_cnt == DEPTH_C);
    net_acc     = net_wr & ~net_full;
    net_nempty  = (net_cnt != '0);
    net_head    = net_mem[net_rp];
    net_type    = net_head[7:0];
    net_ctrl    = net_nempty && (net_head[65:64] == 2'b01);
    net_sof     = net_ctrl && ((net_type == 8'h33) || (net_type == 8'h78));
    net_term    = net_ctrl && ((net_type == 8'h87) || (net_type == 8'h99) ||
                               (net_type == 8'haa) || (net_type == 8'hb4) ||
                               (net_type == 8'hcc) || (net_type == 8'hd2) ||
                               (net_type == 8'he1) || (net_type == 8'hff));
    net_idleblk = net_ctrl && (net_type == 8'h1e);
  end

  // Net FIFO storage
  always_ff @(posedge clk) begin
    if (net_acc) net_mem[net_wp] <= {net_hdr, net_data};
  end

  // Net FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      net_wp  <= '0;
      net_rp  <= '0;
      net_cnt <= '0;
    end else begin
      if (net_acc) net_wp <= net_wp + 1'b1;
      if (net_pop) net_rp <= net_rp + 1'b1;
      net_cnt <= net_cnt + CW'(net_acc) - CW'(net_pop);
    end
  end

  // Sticky overflow flags: a write attempted while full is lost
  always_ff @(posedge clk) begin
    if (reset) ovf <= '0;
    else       ovf <= ovf | {net_wr & net_full, ch_wr & ch_full};
  end

`ifdef IPG_TX_RR_EN
  logic [GW-1:0] rr_ptr;
  logic [GW:0]   rr_idx;
  logic [GW:0]   rr_nxt;
  logic          rr_found;

  // Round-robin search: first pending channel at or after rr_ptr
  always_comb begin
    arb_grant = rr_ptr;
    rr_found  = 1'b0;
    rr_idx    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_idx = {1'b0, rr_ptr} + (GW+1)'(i);
      if (rr_idx >= (GW+1)'(NUM_CH)) rr_idx = rr_idx - (GW+1)'(NUM_CH);
      if (!rr_found && pending[rr_idx[GW-1:0]]) begin
        arb_grant = rr_idx[GW-1:0];
        rr_found  = 1'b1;
      end
    end
    rr_nxt = {1'b0, arb_grant} + 1'b1;
    if (rr_nxt >= (GW+1)'(NUM_CH)) rr_nxt = rr_nxt - (GW+1)'(NUM_CH);
  end

  // Advance the round-robin pointer past each granted channel
  always_ff @(posedge clk) begin
    if (reset)           rr_ptr <= '0;
    else if (grant_load) rr_ptr <= rr_nxt[GW-1:0];
  end
`else
  // Fixed priority: lowest-index pending channel
  always_comb begin
    arb_grant = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) arb_grant = GW'(i);
    end
  end
`endif

  // Grant is frozen for the whole message so it is never interrupted
  always_ff @(posedge clk) begin
    if (reset)           grant <= '0;
    else if (grant_load) grant <= arb_grant;
  end

  // Arbiter FSM: chooses what to pop and what block goes out next cycle.
  // IPG chunks are only started from IDLE, i.e. never inside a net frame.
  always_comb begin
    state_nxt  = state;
    grant_load = 1'b0;
    net_pop    = 1'b0;
    ch_pop     = '0;
    out_hdr    = IDLE_HDR;
    out_data   = IDLE_DATA;
    out_src    = 4'd0;
    case (state)
      S_IDLE: begin
        if (net_sof) begin
          net_pop   = 1'b1;
          out_hdr   = net_head[65:64];
          out_data  = net_head[63:0];
          state_nxt = S_NET;
        end else if (|pending) begin
          grant_load = 1'b1;
          state_nxt  = S_IPG;
        end else if (net_nempty) begin
          net_pop  = 1'b1;
          out_hdr  = net_head[65:64];
          out_data = net_head[63:0];
        end
      end
      S_NET: begin
        if (net_nempty) begin
          net_pop  = 1'b1;
          out_hdr  = net_head[65:64];
          out_data = net_head[63:0];
          if (net_term) state_nxt = S_IDLE;
        end
      end
      S_IPG: begin
        if (ch_cnt[grant] != '0) begin
          ch_pop[grant] = 1'b1;
          out_data      = ch_head[grant][63:0];
          out_src       = 4'(grant) + 4'd1;
          if (ch_head[grant][64]) state_nxt = S_IDLE;
        end
        // Net idle blocks are the slack the IPG chunk replaces
        if (net_idleblk) net_pop = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered transmit outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tx_hdr  <= IDLE_HDR;
      tx_data <= IDLE_DATA;
      tx_src  <= 4'd0;
    end else begin
      state   <= state_nxt;
      tx_hdr  <= out_hdr;
      tx_data <= out_data;
      tx_src  <= out_src;
    end
  end

endmodule

// File: tb/tb_ipg_tx_arb.sv
// tb_ipg_tx_arb: table-driven message/frame vectors plus hand-written
// multi-cycle sequences; every non-idle transmit word is compared against
// a scoreboard queue filled when the stimulus is driven.
module tb_ipg_tx_arb;

  localparam int NUM_CH = 3;
  localparam int DEPTH  = 16;
  localparam int W      = 70;
  localparam logic [W-1:0] IDLE_W = {2'b01, 64'h1e, 4'd0};

  logic                 clk;
  logic                 reset;
  logic [NUM_CH-1:0]    ch_wr;
  logic [64*NUM_CH-1:0] ch_data;
  logic [NUM_CH-1:0]    ch_last;
  logic                 net_wr;
  logic [1:0]           net_hdr;
  logic [63:0]          net_data;
  logic [1:0]           tx_hdr;
  logic [63:0]          tx_data;
  logic [3:0]           tx_src;
  logic [NUM_CH-1:0]    ch_full;
  logic                 net_full;
  logic [NUM_CH:0]      ovf;
  logic [1:0]           dbg_state;

  ipg_tx_arb #(.NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .ch_wr(ch_wr), .ch_data(ch_data), .ch_last(ch_last),
    .net_wr(net_wr), .net_hdr(net_hdr), .net_data(net_data),
    .tx_hdr(tx_hdr), .tx_data(tx_data), .tx_src(tx_src),
    .ch_full(ch_full), .net_full(net_full), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        is_net;
    int          ch;
    int          len;
    logic [31:0] tag;
    logic [3:0]  exp_src;
  } vec_t;

  vec_t         vecs [6];
  logic [W-1:0] exp_q [$];
  logic [3:0]   log_src [$];
  int           log_cyc [$];
  int           n_checks;
  int           n_errors;
  int           cyc;
  logic         sb_en;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Scoreboard: every non-idle word must match the queue head
  task automatic monitor();
    logic [W-1:0] act;
    act = {tx_hdr, tx_data, tx_src};
    if (act != IDLE_W) begin
      log_src.push_back(tx_src);
      log_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("sb_unexpected", act, IDLE_W);
      else                   check("sb_out", act, exp_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sb_en) monitor();
  endtask

  task automatic clear_logs();
    log_src.delete();
    log_cyc.delete();
  endtask

  task automatic ch_write(input int ch, input logic [63:0] d, input logic last);
    ch_wr[ch]             = 1'b1;
    ch_last[ch]           = last;
    ch_data[64*ch +: 64]  = d;
    step();
    ch_wr   = '0;
    ch_last = '0;
  endtask

  task automatic net_write(input logic [1:0] h, input logic [63:0] d);
    net_wr   = 1'b1;
    net_hdr  = h;
    net_data = d;
    step();
    net_wr = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_left", W'(exp_q.size()), '0);
    exp_q.delete();
    repeat (4) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] d;
    logic [1:0]  h;
    logic [63:0] a0, a1, b0, b1;
    logic [3:0]  ord [4];
    int          n;

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    sb_en    = 1'b1;
    ch_wr    = '0;
    ch_data  = '0;
    ch_last  = '0;
    net_wr   = 1'b0;
    net_hdr  = 2'b00;
    net_data = '0;
    reset    = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    check("rst_tx", {tx_hdr, tx_data, tx_src}, IDLE_W);
    check("rst_full", W'({ch_full, net_full}), '0);
    check("rst_ovf", W'(ovf), '0);
    check("rst_state", W'(dbg_state), '0);

    // Vector table: {is_net, ch, len, tag, expected tx_src}
    vecs[0] = '{1'b0, 1, 3,  32'h1111_0001, 4'd2};
    vecs[1] = '{1'b0, 0, 1,  32'h2222_0002, 4'd1};
    vecs[2] = '{1'b0, 2, 5,  32'h3333_0003, 4'd3};
    vecs[3] = '{1'b1, 0, 4,  32'h4444_0004, 4'd0};
    vecs[4] = '{1'b0, 2, 16, 32'h5555_0005, 4'd3};
    vecs[5] = '{1'b1, 0, 2,  32'h6666_0006, 4'd0};

    for (int v = 0; v < 6; v++) begin
      clear_logs();
      for (int i = 0; i < vecs[v].len; i++) begin
        if (!vecs[v].is_net) begin
          d = {vecs[v].tag, 32'($urandom())};
          exp_q.push_back({2'b01, d, vecs[v].exp_src});
          ch_write(vecs[v].ch, d, (i == vecs[v].len - 1));
        end else begin
          d = {vecs[v].tag, 32'($urandom())};
          h = 2'b10;
          if (i == 0) begin
            h = 2'b01;
            d[7:0] = 8'h33;
          end else if (i == vecs[v].len - 1) begin
            h = 2'b01;
            d[7:0] = 8'h87;
          end
          exp_q.push_back({h, d, 4'd0});
          net_write(h, d);
        end
      end
      drain(100);
      check("vec_count", W'(log_src.size()), W'(vecs[v].len));
      if (log_cyc.size() == vecs[v].len)
        check("vec_contig", W'(log_cyc[vecs[v].len-1] - log_cyc[0]), W'(vecs[v].len - 1));
      check("vec_state_idle", W'(dbg_state), '0);
    end

    // Channel message queued before a net frame: IPG first, frame contiguous
    clear_logs();
    for (int i = 0; i < 2; i++) begin
      d = {32'h0a0a_0000, 32'($urandom())};
      exp_q.push_back({2'b01, d, 4'd1});
      ch_write(0, d, (i == 1));
    end
    for (int i = 0; i < 6; i++) begin
      d = {32'($urandom()), 32'($urandom())};
      h = 2'b10;
      if (i == 0) begin
        h = 2'b01;
        d[7:0] = 8'h78;
      end else if (i == 5) begin
        h = 2'b01;
        d[7:0] = 8'hff;
      end
      exp_q.push_back({h, d, 4'd0});
      net_write(h, d);
    end
    drain(60);
    check("frame_count", W'(log_src.size()), W'(8));
    if (log_src.size() == 8) begin
      check("frame_ipg0_src", W'(log_src[0]), W'(1));
      check("frame_ipg1_src", W'(log_src[1]), W'(1));
      check("frame_sof_src", W'(log_src[2]), W'(0));
      check("frame_contig", W'(log_cyc[7] - log_cyc[2]), W'(5));
    end

    // Arbitration order with ch0 and ch2 each holding two messages
    clear_logs();
    a0 = {32'hc0c0_0000, 32'($urandom())};
    a1 = {32'hc0c0_0001, 32'($urandom())};
    b0 = {32'hc2c2_0000, 32'($urandom())};
    b1 = {32'hc2c2_0001, 32'($urandom())};
`ifdef IPG_TX_RR_EN
    exp_q.push_back({2'b01, a0, 4'd1});
    exp_q.push_back({2'b01, b0, 4'd3});
    exp_q.push_back({2'b01, a1, 4'd1});
    exp_q.push_back({2'b01, b1, 4'd3});
    ord = '{4'd1, 4'd3, 4'd1, 4'd3};
`else
    exp_q.push_back({2'b01, a0, 4'd1});
    exp_q.push_back({2'b01, a1, 4'd1});
    exp_q.push_back({2'b01, b0, 4'd3});
    exp_q.push_back({2'b01, b1, 4'd3});
    ord = '{4'd1, 4'd1, 4'd3, 4'd3};
`endif
    ch_wr = 3'b101;
    ch_last = 3'b101;
    ch_data[63:0] = a0;
    ch_data[191:128] = b0;
    step();
    ch_data[63:0] = a1;
    ch_data[191:128] = b1;
    step();
    ch_wr = '0;
    ch_last = '0;
    drain(60);
    check("arb_count", W'(log_src.size()), W'(4));
    if (log_src.size() == 4)
      for (int i = 0; i < 4; i++) check("arb_order", W'(log_src[i]), W'(ord[i]));

    // IDLE blocks consumed during IPG; SOF follows the last chunk directly
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      d = {32'h2727_0000, 32'($urandom())};
      exp_q.push_back({2'b01, d, 4'd3});
      ch_write(2, d, (i == 2));
    end
    for (int i = 0; i < 3; i++) net_write(2'b01, 64'h1e);
    d = {32'($urandom()), 32'($urandom())};
    d[7:0] = 8'h33;
    exp_q.push_back({2'b01, d, 4'd0});
    net_write(2'b01, d);
    d = {32'($urandom()), 32'($urandom())};
    d[7:0] = 8'haa;
    exp_q.push_back({2'b01, d, 4'd0});
    net_write(2'b01, d);
    drain(60);
    check("rm_count", W'(log_src.size()), W'(5));
    if (log_src.size() == 5) begin
      check("rm_sof_src", W'(log_src[3]), W'(0));
      check("rm_sof_next", W'(log_cyc[3] - log_cyc[2]), W'(1));
    end

    // Net FIFO overflow: SOF held behind a 16-chunk IPG message
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      d = {32'h0f0f_0000, 32'($urandom())};
      exp_q.push_back({2'b01, d, 4'd1});
      ch_write(0, d, (i == 15));
    end
    check("ch0_full_16", W'(ch_full), W'(3'b001));
    for (int i = 0; i < 17; i++) begin
      d = {32'($urandom()), 32'($urandom())};
      h = 2'b10;
      if (i == 0) begin
        h = 2'b01;
        d[7:0] = 8'h78;
      end
      if (i < 16) exp_q.push_back({h, d, 4'd0});
      net_write(h, d);
      if (i == 15) check("net_full_16", W'(net_full), W'(1));
    end
    check("ovf_net", W'(ovf), W'(4'b1000));
    drain(100);
    check("ovf_net_sticky", W'(ovf), W'(4'b1000));
    check("net_empty_stays_net", W'(dbg_state), W'(1));
    do_reset();
    check("ovf_net_rst", W'(ovf), '0);
    check("state_rst", W'(dbg_state), '0);

    // Channel overflow: 17 writes without a last chunk, nothing drains
    for (int i = 0; i < 17; i++) begin
      ch_write(0, {32'hdead_0000, 32'(i)}, 1'b0);
      if (i == 14) check("ch0_full_15", W'(ch_full), '0);
      if (i == 15) check("ch0_full_16b", W'(ch_full), W'(3'b001));
      if (i == 15) check("ovf_before_17", W'(ovf), '0);
    end
    check("ch0_full_17", W'(ch_full), W'(3'b001));
    check("ovf_ch0", W'(ovf), W'(4'b0001));
    repeat (5) step();
    check("ovf_ch0_sticky", W'(ovf), W'(4'b0001));
    do_reset();
    check("ovf_ch0_rst", W'(ovf), '0);
    check("ch_full_rst", W'(ch_full), '0);

    // Reset in the middle of an IPG message
    sb_en = 1'b0;
    for (int i = 0; i < 4; i++) ch_write(0, {32'hbeef_0000, 32'(i)}, (i == 3));
    n = 0;
    while (tx_src != 4'd1 && n < 20) begin
      step();
      n++;
    end
    check("mid_ipg_seen", W'(tx_src), W'(1));
    reset = 1'b1;
    step();
    check("mid_rst_tx", {tx_hdr, tx_data, tx_src}, IDLE_W);
    check("mid_rst_full", W'(ch_full), '0);
    check("mid_rst_ovf", W'(ovf), '0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_idle", {tx_hdr, tx_data, tx_src}, IDLE_W);
    end
    sb_en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
